support_point_search: RTL and testbench

//  Responder side of the sup_start/done handshake used by the SAT collision path.

---
 rtl/support_point_search_pkg.sv | 16 +
 rtl/support_point_search_if.sv | 45 ++++
 rtl/support_point_search_dot2_signed.sv | 24 ++
 rtl/support_point_search.sv | 170 +++++++++++++++++
 tb/tb_support_point_search.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/support_point_search_pkg.sv
// rtl/support_point_search_pkg.sv - shared widths, Q-format constant and FSM encoding for the support-point search
package support_point_search_pkg;

  localparam int DEF_COORD_W = 19;
  localparam int DEF_DIR_W   = 10;
  localparam int DEF_DOT_W   = DEF_COORD_W + DEF_DIR_W + 1;
  localparam int FRAC_BITS   = 8;
  localparam int NUM_VERTS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/support_point_search_if.sv
// rtl/support_point_search_if.sv - sup_start/done request bus between the penetration search and the support-point search
// Optional SUPPORT_BEST_DOT_EN adds bestIndex/bestDot to the response side.
interface support_point_search_if
  import support_point_search_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int DIR_W   = DEF_DIR_W
);
  localparam int DOT_W = COORD_W + DIR_W + 1;

  logic                      sup_start;
  logic signed [COORD_W-1:0] v0_x, v1_x, v2_x, v3_x;
  logic signed [COORD_W-1:0] v0_y, v1_y, v2_y, v3_y;
  logic signed [COORD_W-1:0] pos_x, pos_y;
  logic signed [DIR_W-1:0]   dir_x, dir_y;
  logic signed [COORD_W-1:0] bestVertex_x, bestVertex_y;
  logic                      done;
`ifdef SUPPORT_BEST_DOT_EN
  logic [1:0]                bestIndex;
  logic signed [DOT_W-1:0]   bestDot;

  modport master (
    output sup_start, v0_x, v1_x, v2_x, v3_x, v0_y, v1_y, v2_y, v3_y,
           pos_x, pos_y, dir_x, dir_y,
    input  bestVertex_x, bestVertex_y, done, bestIndex, bestDot
  );
  modport slave (
    input  sup_start, v0_x, v1_x, v2_x, v3_x, v0_y, v1_y, v2_y, v3_y,
           pos_x, pos_y, dir_x, dir_y,
    output bestVertex_x, bestVertex_y, done, bestIndex, bestDot
  );
`else
  modport master (
    output sup_start, v0_x, v1_x, v2_x, v3_x, v0_y, v1_y, v2_y, v3_y,
           pos_x, pos_y, dir_x, dir_y,
    input  bestVertex_x, bestVertex_y, done
  );
  modport slave (
    input  sup_start, v0_x, v1_x, v2_x, v3_x, v0_y, v1_y, v2_y, v3_y,
           pos_x, pos_y, dir_x, dir_y,
    output bestVertex_x, bestVertex_y, done
  );
`endif

endinterface

// File: rtl/support_point_search_dot2_signed.sv
// rtl/support_point_search_dot2_signed.sv - combinational full-width signed 2-term dot product a.b
module dot2_signed #(
  parameter int A_W = 19,
  parameter int B_W = 10
) (
  input  logic signed [A_W-1:0]     a_x,
  input  logic signed [A_W-1:0]     a_y,
  input  logic signed [B_W-1:0]     b_x,
  input  logic signed [B_W-1:0]     b_y,
  output logic signed [A_W+B_W:0]   p
);
  localparam int P_W = A_W + B_W + 1;

  // Operands widened first so the multiply and sum happen at the result width.
  logic signed [P_W-1:0] ax_w, ay_w, bx_w, by_w;

  assign ax_w = {{(P_W-A_W){a_x[A_W-1]}}, a_x};
  assign ay_w = {{(P_W-A_W){a_y[A_W-1]}}, a_y};
  assign bx_w = {{(P_W-B_W){b_x[B_W-1]}}, b_x};
  assign by_w = {{(P_W-B_W){b_y[B_W-1]}}, b_y};

  assign p = ax_w * bx_w + ay_w * by_w;

endmodule

// File: rtl/support_point_search.sv
// rtl/support_point_search.sv - scans 4 box vertices one per cycle, returns the world vertex furthest along dir
// Optional SUPPORT_BEST_DOT_EN registers the winning index and dot product alongside bestVertex.
module support_point_search
  import support_point_search_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int DIR_W   = DEF_DIR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  support_point_search_if.slave  sup
);
  localparam int DOT_W = COORD_W + DIR_W + 1;

  state_e                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [1:0]                best_idx_q, best_idx_d;
  logic signed [DOT_W-1:0]   best_dot_q, best_dot_d;
  logic signed [COORD_W-1:0] vx_q [NUM_VERTS];
  logic signed [COORD_W-1:0] vx_d [NUM_VERTS];
  logic signed [COORD_W-1:0] vy_q [NUM_VERTS];
  logic signed [COORD_W-1:0] vy_d [NUM_VERTS];
  logic signed [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [DIR_W-1:0]   dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic signed [COORD_W-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic                      done_q, done_d;
`ifdef SUPPORT_BEST_DOT_EN
  logic [1:0]                out_idx_q, out_idx_d;
  logic signed [DOT_W-1:0]   out_dot_q, out_dot_d;
`endif

  logic signed [DOT_W-1:0]   cur_dot;
  logic                      take;
  logic [1:0]                sel_idx;
  logic signed [DOT_W-1:0]   sel_dot;

  dot2_signed #(
    .A_W (COORD_W),
    .B_W (DIR_W)
  ) u_dot (
    .a_x (vx_q[idx_q]),
    .a_y (vy_q[idx_q]),
    .b_x (dir_x_q),
    .b_y (dir_y_q),
    .p   (cur_dot)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_dot_d = best_dot_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    done_d     = 1'b0;
`ifdef SUPPORT_BEST_DOT_EN
    out_idx_d  = out_idx_q;
    out_dot_d  = out_dot_q;
`endif

    // Strict compare: on a tie the earlier (lower-index) vertex is kept.
    take    = (idx_q == 2'd0) || (cur_dot > best_dot_q);
    sel_idx = take ? idx_q : best_idx_q;
    sel_dot = take ? cur_dot : best_dot_q;

    unique case (state_q)
      ST_SCAN: begin
        best_idx_d = sel_idx;
        best_dot_d = sel_dot;
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          out_x_d = vx_q[sel_idx] + pos_x_q;
          out_y_d = vy_q[sel_idx] + pos_y_q;
`ifdef SUPPORT_BEST_DOT_EN
          out_idx_d = sel_idx;
          out_dot_d = sel_dot;
`endif
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = state_q;
    endcase

    // A new request in any state restarts the scan and suppresses the
    // result of the search it interrupts.
    if (sup.sup_start) begin
      vx_d[0] = sup.v0_x;
      vx_d[1] = sup.v1_x;
      vx_d[2] = sup.v2_x;
      vx_d[3] = sup.v3_x;
      vy_d[0] = sup.v0_y;
      vy_d[1] = sup.v1_y;
      vy_d[2] = sup.v2_y;
      vy_d[3] = sup.v3_y;
      pos_x_d = sup.pos_x;
      pos_y_d = sup.pos_y;
      dir_x_d = sup.dir_x;
      dir_y_d = sup.dir_y;
      idx_d   = 2'd0;
      state_d = ST_SCAN;
      done_d  = 1'b0;
      out_x_d = out_x_q;
      out_y_d = out_y_q;
`ifdef SUPPORT_BEST_DOT_EN
      out_idx_d = out_idx_q;
      out_dot_d = out_dot_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      best_idx_q <= 2'd0;
      best_dot_q <= '0;
      for (int i = 0; i < NUM_VERTS; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      dir_x_q    <= '0;
      dir_y_q    <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      done_q     <= 1'b0;
`ifdef SUPPORT_BEST_DOT_EN
      out_idx_q  <= 2'd0;
      out_dot_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_dot_q <= best_dot_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      done_q     <= done_d;
`ifdef SUPPORT_BEST_DOT_EN
      out_idx_q  <= out_idx_d;
      out_dot_q  <= out_dot_d;
`endif
    end
  end

  assign sup.bestVertex_x = out_x_q;
  assign sup.bestVertex_y = out_y_q;
  assign sup.done         = done_q;
`ifdef SUPPORT_BEST_DOT_EN
  assign sup.bestIndex    = out_idx_q;
  assign sup.bestDot      = out_dot_q;
`endif

endmodule

// File: tb/tb_support_point_search.sv
// tb/tb_support_point_search.sv - scoreboard bench for support_point_search against an arithmetic reference model
// Also checks bestIndex/bestDot when SUPPORT_BEST_DOT_EN is defined.
module tb_support_point_search;
  import support_point_search_pkg::*;

  localparam int CW = DEF_COORD_W;
  localparam int DW = DEF_DIR_W;

  typedef struct {
    int     due;
    int     x;
    int     y;
    int     idx;
    longint dot;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   held_x = 0;
  int   held_y = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int sq_x[4];
  int sq_y[4];
  int rvx[4];
  int rvy[4];

  support_point_search_if #(.COORD_W(CW), .DIR_W(DW)) bus ();

  support_point_search #(.COORD_W(CW), .DIR_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .sup (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int rnd_signed(input int w);
    int r;
    r = int'($urandom_range(0, (1 << w) - 1));
    if (r >= (1 << (w - 1))) r -= (1 << w);
    return r;
  endfunction

  function automatic int wrap_coord(input longint v);
    logic signed [CW-1:0] t;
    t = CW'(v);
    return int'(t);
  endfunction

  // Reference: pick max dot, first index wins ties, world coordinate wraps at CW bits.
  function automatic exp_t model(input int vx[4], input int vy[4],
                                 input int px, input int py, input int dx, input int dy);
    exp_t   e;
    longint d;
    e.idx = 0;
    e.dot = longint'(vx[0]) * dx + longint'(vy[0]) * dy;
    for (int i = 1; i < 4; i++) begin
      d = longint'(vx[i]) * dx + longint'(vy[i]) * dy;
      if (d > e.dot) begin
        e.dot = d;
        e.idx = i;
      end
    end
    e.x   = wrap_coord(longint'(vx[e.idx]) + px);
    e.y   = wrap_coord(longint'(vy[e.idx]) + py);
    e.due = 0;
    return e;
  endfunction

  task automatic scramble_inputs();
    bus.v0_x  = CW'($urandom); bus.v1_x = CW'($urandom);
    bus.v2_x  = CW'($urandom); bus.v3_x = CW'($urandom);
    bus.v0_y  = CW'($urandom); bus.v1_y = CW'($urandom);
    bus.v2_y  = CW'($urandom); bus.v3_y = CW'($urandom);
    bus.pos_x = CW'($urandom); bus.pos_y = CW'($urandom);
    bus.dir_x = DW'($urandom); bus.dir_y = DW'($urandom);
  endtask

  // Called at posedge+#1; the request is sampled at the next edge (cycle T = cyc).
  task automatic issue(input int vx[4], input int vy[4],
                       input int px, input int py, input int dx, input int dy);
    exp_t e;
    if (sb.size() > 0 && sb[sb.size()-1].due > cyc) sb.delete(sb.size() - 1);
    e     = model(vx, vy, px, py, dx, dy);
    e.due = cyc + 5;
    sb.push_back(e);
    bus.v0_x = CW'(vx[0]); bus.v1_x = CW'(vx[1]); bus.v2_x = CW'(vx[2]); bus.v3_x = CW'(vx[3]);
    bus.v0_y = CW'(vy[0]); bus.v1_y = CW'(vy[1]); bus.v2_y = CW'(vy[2]); bus.v3_y = CW'(vy[3]);
    bus.pos_x = CW'(px);
    bus.pos_y = CW'(py);
    bus.dir_x = DW'(dx);
    bus.dir_y = DW'(dy);
    bus.sup_start = 1'b1;
    @(posedge clk);
    #1;
    bus.sup_start = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_then_next();
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL done_wait_timeout: %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", cyc, mon_e.due);
          check("best_x", bus.bestVertex_x, mon_e.x);
          check("best_y", bus.bestVertex_y, mon_e.y);
`ifdef SUPPORT_BEST_DOT_EN
          check("best_index", bus.bestIndex, mon_e.idx);
          check("best_dot", bus.bestDot, mon_e.dot);
`endif
          held_x = mon_e.x;
          held_y = mon_e.y;
        end
      end else begin
        check("hold_x", bus.bestVertex_x, held_x);
        check("hold_y", bus.bestVertex_y, held_y);
      end
    end
  end

  initial begin
    sq_x = '{-256, 256, 256, -256};
    sq_y = '{-256, -256, 256, 256};
    bus.sup_start = 1'b0;
    scramble_inputs();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_done", bus.done, 0);
    check("reset_x", bus.bestVertex_x, 0);
    check("reset_y", bus.bestVertex_y, 0);
    @(posedge clk);
    #1;

    // v1/v2 tie along +x, lower index wins
    issue(sq_x, sq_y, 1000, 0, 256, 0);
    wait_quiet();

    issue(sq_x, sq_y, 1000, 0, 0, -256);
    wait_quiet();
    issue(sq_x, sq_y, 1000, 0, -181, 181);
    wait_quiet();

    // restart two cycles in: only the second search reports
    issue(sq_x, sq_y, 1000, 0, 256, 0);
    @(posedge clk);
    #1;
    issue(sq_x, sq_y, 1000, 0, -256, 0);
    wait_quiet();

    // reset at T+3 kills the search and clears bestVertex
    issue(sq_x, sq_y, 1000, 0, 256, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    held_x = 0;
    held_y = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_x", bus.bestVertex_x, 0);
    check("post_rst_y", bus.bestVertex_y, 0);
    repeat (8) @(posedge clk);
    #1;
    issue(sq_x, sq_y, 1000, 0, 256, 0);
    wait_quiet();

    // initiator pattern: each request the cycle after the previous done
    issue(sq_x, sq_y, 1000, 0, 256, 0);
    wait_done_then_next();
    issue(sq_x, sq_y, 1000, 0, 0, 256);
    wait_done_then_next();
    issue(sq_x, sq_y, 1000, 0, -256, 0);
    wait_done_then_next();
    issue(sq_x, sq_y, 1000, 0, 0, -256);
    wait_quiet();

    // zero direction selects v0; large pos exercises the top of the range
    issue(sq_x, sq_y, 262143, 0, 0, 0);
    wait_quiet();
    issue(sq_x, sq_y, 262143, -262144, 256, 256);
    wait_quiet();

    // random requests with random gaps: covers aborts, coincident and back-to-back starts
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 4; k++) begin
        rvx[k] = rnd_signed(CW);
        rvy[k] = rnd_signed(CW);
      end
      if ($urandom_range(0, 3) == 0) begin
        rvx[2] = rvx[0];
        rvy[2] = rvy[0];
      end
      if ($urandom_range(0, 7) == 0)
        issue(rvx, rvy, rnd_signed(CW), rnd_signed(CW), 0, 0);
      else
        issue(rvx, rvy, rnd_signed(CW), rnd_signed(CW), rnd_signed(DW), rnd_signed(DW));
      repeat ($urandom_range(0, 7)) @(posedge clk);
      #1;
    end
    wait_quiet();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
